// File: rtl/motor_pkg.sv
// Shared definitions for the differential-drive ramp controller: mode and state
// encodings plus the mode-to-drive lookup table.
package motor_pkg;

  localparam int unsigned DutyW = 10;

  localparam logic [DutyW-1:0] DutyFull = 10'd300;
  localparam logic [DutyW-1:0] DutyHalf = 10'd150;

  typedef enum logic [2:0] {
    ModeStop      = 3'd0,
    ModeFwd       = 3'd1,
    ModeLeft      = 3'd2,
    ModeRight     = 3'd3,
    ModeSpinLeft  = 3'd4,
    ModeSpinRight = 3'd5,
    ModeReverse   = 3'd6,
    ModeHalt      = 3'd7
  } mode_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRamp  = 3'd1,
    StBrake = 3'd2,
    StDead  = 3'd3,
    StRun   = 3'd4
  } state_e;

  // dir is {left, right}; 1 means the wheel runs in reverse.
  typedef struct packed {
    logic [DutyW-1:0] left_duty;
    logic [DutyW-1:0] right_duty;
    logic [1:0]       dir;
  } drive_t;

  // Stop modes keep the current direction so that stopping never forces a brake.
  function automatic drive_t mode_lookup(input logic [2:0] mode, input logic [1:0] dir_cur);
    drive_t d;
    d.left_duty  = DutyFull;
    d.right_duty = DutyFull;
    d.dir        = 2'b00;
    case (mode_e'(mode))
      ModeFwd:       d.dir = 2'b00;
      ModeLeft:      d.left_duty = DutyHalf;
      ModeRight:     d.right_duty = DutyHalf;
      ModeSpinLeft:  d.dir = 2'b10;
      ModeSpinRight: d.dir = 2'b01;
      ModeReverse:   d.dir = 2'b11;
      default: begin
        d.left_duty  = '0;
        d.right_duty = '0;
        d.dir        = dir_cur;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/duty_ramp.sv
// One wheel's duty register: on each enabled cycle it moves toward the target by
// at most STEP, landing exactly on the target without overshoot or wrap.
module duty_ramp
  import motor_pkg::*;
#(
  parameter int unsigned STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             clear,
  input  logic [DutyW-1:0] target,
  output logic [DutyW-1:0] duty,
  output logic [DutyW-1:0] duty_next
);

  logic [DutyW-1:0] duty_q;
  logic [DutyW-1:0] diff;
  logic [DutyW-1:0] step_amt;

  always_comb begin
    diff = (target >= duty_q) ? (target - duty_q) : (duty_q - target);
    step_amt = (32'(diff) < STEP) ? diff : DutyW'(STEP);
    duty_next = duty_q;
    if (clear) begin
      duty_next = '0;
    end else if (step_en) begin
      duty_next = (target > duty_q) ? (duty_q + step_amt) : (duty_q - step_amt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_next;
    end
  end

  assign duty = duty_q;

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Two-wheel duty ramp controller: accepts motion modes, ramps both PWM duties on a
// slow tick, and brakes to zero with a dead time before any direction reversal.
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned STEP       = 8,
  parameter int unsigned DEAD_TICKS = 4,
  parameter int unsigned DUTY_MAX   = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             mode_valid,
  output logic             mode_ready,
  input  logic             estop,
  output logic [DutyW-1:0] left_duty,
  output logic [DutyW-1:0] right_duty,
  output logic [1:0]       dir,
  output logic             settled
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam int unsigned DeadW = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;
  localparam logic [DeadW-1:0] DeadLast = DeadW'(DEAD_TICKS);
  localparam logic [DutyW-1:0] DutyCap = (DUTY_MAX > 1023) ? 10'd1023 : DutyW'(DUTY_MAX);

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick;
  logic [DeadW-1:0] dead_cnt_q, dead_cnt_d;
  logic             dead_done;
  logic [DutyW-1:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic [DutyW-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [1:0]       pend_dir_q, pend_dir_d;
  logic [1:0]       dir_q, dir_d;
  logic             settled_q, settled_d;
  logic             live_q;
  logic             accept;
  logic             brake_req;
  logic             at_target;
  logic             step_en;
  logic [DutyW-1:0] l_next, r_next;
  drive_t           cmd_raw, cmd;

  // Free-running tick; it never restarts on commands so the ramp cadence stays fixed.
  assign tick = (tick_cnt_q == TickLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    cmd_raw = mode_lookup(mode, dir_q);
    cmd = cmd_raw;
    cmd.left_duty  = (cmd_raw.left_duty > DutyCap) ? DutyCap : cmd_raw.left_duty;
    cmd.right_duty = (cmd_raw.right_duty > DutyCap) ? DutyCap : cmd_raw.right_duty;
  end

  assign accept    = mode_valid && mode_ready;
  assign brake_req = ((cmd.dir[1] != dir_q[1]) && (left_duty != '0)) ||
                     ((cmd.dir[0] != dir_q[0]) && (right_duty != '0));
  assign at_target = (left_duty == tgt_l_q) && (right_duty == tgt_r_q);
  assign dead_done = (dead_cnt_q == DeadLast);
  assign step_en   = tick && ((state_q == StRamp) || (state_q == StBrake));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (estop) begin
      state_d = StIdle;
    end else if (accept) begin
      state_d = brake_req ? StBrake : StRamp;
    end else begin
      case (state_q)
        StRamp: begin
          if (at_target) begin
            state_d = ((tgt_l_q | tgt_r_q) == '0) ? StIdle : StRun;
          end
        end
        StBrake: begin
          if ((left_duty == '0) && (right_duty == '0)) begin
            state_d = StDead;
          end
        end
        StDead: begin
          if (dead_done) begin
            state_d = StRamp;
          end
        end
        default: ;
      endcase
    end
  end

  // Targets, pending command and direction
  always_comb begin
    tgt_l_d    = tgt_l_q;
    tgt_r_d    = tgt_r_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    pend_dir_d = pend_dir_q;
    dir_d      = dir_q;
    dead_cnt_d = '0;
    if (state_q == StDead && !estop) begin
      dead_cnt_d = (tick && !dead_done) ? dead_cnt_q + 1'b1 : dead_cnt_q;
    end
    if (estop) begin
      tgt_l_d  = '0;
      tgt_r_d  = '0;
      pend_l_d = '0;
      pend_r_d = '0;
    end else if (accept) begin
      if (brake_req) begin
        tgt_l_d    = '0;
        tgt_r_d    = '0;
        pend_l_d   = cmd.left_duty;
        pend_r_d   = cmd.right_duty;
        pend_dir_d = cmd.dir;
      end else begin
        tgt_l_d = cmd.left_duty;
        tgt_r_d = cmd.right_duty;
        dir_d   = cmd.dir;
      end
    end else if (state_q == StDead && dead_done) begin
      tgt_l_d = pend_l_q;
      tgt_r_d = pend_r_q;
      dir_d   = pend_dir_q;
    end
  end

  // Outputs; mode_ready stays low until the first edge after reset release.
  always_comb begin
    mode_ready = live_q && !estop &&
                 ((state_q == StIdle) || (state_q == StRamp) || (state_q == StRun));
    settled_d  = !accept && ((state_d == StIdle) || (state_d == StRun)) &&
                 (l_next == tgt_l_d) && (r_next == tgt_r_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dead_cnt_q <= '0;
      tgt_l_q    <= '0;
      tgt_r_q    <= '0;
      pend_l_q   <= '0;
      pend_r_q   <= '0;
      pend_dir_q <= 2'b00;
      dir_q      <= 2'b00;
      settled_q  <= 1'b1;
      live_q     <= 1'b0;
    end else begin
      dead_cnt_q <= dead_cnt_d;
      tgt_l_q    <= tgt_l_d;
      tgt_r_q    <= tgt_r_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      pend_dir_q <= pend_dir_d;
      dir_q      <= dir_d;
      settled_q  <= settled_d;
      live_q     <= 1'b1;
    end
  end

  duty_ramp #(
    .STEP(STEP)
  ) u_left (
    .clk      (clk),
    .rst      (rst),
    .step_en  (step_en),
    .clear    (estop),
    .target   (tgt_l_q),
    .duty     (left_duty),
    .duty_next(l_next)
  );

  duty_ramp #(
    .STEP(STEP)
  ) u_right (
    .clk      (clk),
    .rst      (rst),
    .step_en  (step_en),
    .clear    (estop),
    .target   (tgt_r_q),
    .duty     (right_duty),
    .duty_next(r_next)
  );

  assign dir     = dir_q;
  assign settled = settled_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with a short tick: mode table walk plus
// hand-written ramp, brake/dead, estop and asynchronous reset sequences.
module tb_motor_ramp_ctrl;

  localparam int TickDiv   = 4;
  localparam int Step      = 8;
  localparam int DeadTicks = 2;
  localparam int DutyMax   = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       mode_valid = 1'b0;
  logic       estop = 1'b0;
  logic       mode_ready;
  logic [9:0] left_duty;
  logic [9:0] right_duty;
  logic [1:0] dir;
  logic       settled;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0] mode;
    int         l;
    int         r;
    int         d;
  } vec_t;

  vec_t vecs[9];

  motor_ramp_ctrl #(
    .TICK_DIV  (TickDiv),
    .STEP      (Step),
    .DEAD_TICKS(DeadTicks),
    .DUTY_MAX  (DutyMax)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .mode_valid(mode_valid),
    .mode_ready(mode_ready),
    .estop     (estop),
    .left_duty (left_duty),
    .right_duty(right_duty),
    .dir       (dir),
    .settled   (settled)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input string nm, input logic [2:0] m);
    int n = 0;
    while (!mode_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ready"}, int'(mode_ready), 1);
    mode = m;
    mode_valid = 1'b1;
    @(negedge clk);
    mode_valid = 1'b0;
    check({nm, "_settled_drop"}, int'(settled), 0);
  endtask

  task automatic wait_settled(input string nm);
    int n = 0;
    while (!settled && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_settle_in_time"}, int'(n < 2000), 1);
  endtask

  task automatic wait_left(input string nm, input int val);
    int n = 0;
    while (int'(left_duty) != val && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_left_reached"}, int'(left_duty), val);
  endtask

  // Follows one wheel, checking each change is one clamped step and changes are TickDiv apart.
  task automatic ramp_watch(input string nm, input bit use_left, input int target,
                            input int exp_steps, input int rdy_exp, input int other_exp);
    int prev, cur, nxt;
    int steps = 0;
    int last = -1;
    int cyc = 0;
    int val_err = 0;
    int cad_err = 0;
    int side_err = 0;
    prev = use_left ? int'(left_duty) : int'(right_duty);
    while (prev != target && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      cur = use_left ? int'(left_duty) : int'(right_duty);
      if (rdy_exp >= 0 && int'(mode_ready) != rdy_exp) side_err++;
      if (other_exp >= 0 && int'(use_left ? right_duty : left_duty) != other_exp) side_err++;
      if (cur != prev) begin
        if (target > prev) nxt = (target - prev < Step) ? target : prev + Step;
        else nxt = (prev - target < Step) ? target : prev - Step;
        if (cur != nxt) val_err++;
        if (last >= 0 && cyc - last != TickDiv) cad_err++;
        last = cyc;
        steps++;
        prev = cur;
      end
    end
    check({nm, "_reached"}, prev, target);
    check({nm, "_steps"}, steps, exp_steps);
    check({nm, "_step_values"}, val_err, 0);
    check({nm, "_cadence"}, cad_err, 0);
    check({nm, "_side"}, side_err, 0);
  endtask

  initial begin
    int n;
    int err;
    vecs[0] = '{3'd0, 0, 0, 3};
    vecs[1] = '{3'd1, 300, 300, 0};
    vecs[2] = '{3'd2, 150, 300, 0};
    vecs[3] = '{3'd3, 300, 150, 0};
    vecs[4] = '{3'd4, 300, 300, 2};
    vecs[5] = '{3'd5, 300, 300, 1};
    vecs[6] = '{3'd6, 300, 300, 3};
    vecs[7] = '{3'd7, 0, 0, 3};
    vecs[8] = '{3'd1, 300, 300, 0};

    // Reset state
    #12;
    check("rst_left", int'(left_duty), 0);
    check("rst_right", int'(right_duty), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_settled", int'(settled), 1);
    check("rst_ready", int'(mode_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_before_first_edge", int'(mode_ready), 0);
    @(negedge clk);
    check("ready_after_first_edge", int'(mode_ready), 1);

    // Forward ramp from rest
    send("fwd", 3'd1);
    ramp_watch("fwd_ramp", 1'b1, 300, 38, 1, -1);
    wait_settled("fwd");
    check("fwd_right", int'(right_duty), 300);
    check("fwd_dir", int'(dir), 0);

    // Left turn from forward run: no brake, right wheel untouched
    send("turn", 3'd2);
    ramp_watch("turn_ramp", 1'b1, 150, 19, 1, 300);
    wait_settled("turn");
    check("turn_left", int'(left_duty), 150);

    send("fwd2", 3'd1);
    wait_settled("fwd2");

    // Reverse from forward: brake, dead time, then ramp with new direction
    send("rev", 3'd6);
    ramp_watch("rev_brake", 1'b1, 0, 38, 0, -1);
    check("rev_brake_right", int'(right_duty), 0);
    n = 0;
    err = 0;
    while (dir != 2'b11 && n < 40) begin
      @(negedge clk);
      n++;
      if (dir != 2'b11 && (mode_ready || left_duty != 0 || right_duty != 0)) err++;
    end
    check("dead_len_in_range", int'(n >= 8 && n <= 12), 1);
    check("dead_held", err, 0);
    ramp_watch("rev_ramp", 1'b1, 300, 38, 1, -1);
    wait_settled("rev");
    check("rev_right", int'(right_duty), 300);
    check("rev_dir", int'(dir), 3);

    // Mode table walk
    for (int i = 0; i < 9; i++) begin
      send($sformatf("vec%0d", i), vecs[i].mode);
      wait_settled($sformatf("vec%0d", i));
      check($sformatf("vec%0d_left", i), int'(left_duty), vecs[i].l);
      check($sformatf("vec%0d_right", i), int'(right_duty), vecs[i].r);
      check($sformatf("vec%0d_dir", i), int'(dir), vecs[i].d);
    end

    // Emergency stop mid-ramp with a command on the same edge
    send("stop", 3'd0);
    wait_settled("stop");
    send("fwd3", 3'd1);
    wait_left("estop_pre", 120);
    estop = 1'b1;
    mode = 3'd6;
    mode_valid = 1'b1;
    #1;
    check("estop_ready_low", int'(mode_ready), 0);
    @(negedge clk);
    check("estop_left", int'(left_duty), 0);
    check("estop_right", int'(right_duty), 0);
    check("estop_dir", int'(dir), 0);
    repeat (3) @(negedge clk);
    check("estop_ready_held", int'(mode_ready), 0);
    estop = 1'b0;
    mode_valid = 1'b0;
    @(negedge clk);
    check("estop_idle_ready", int'(mode_ready), 1);
    check("estop_idle_settled", int'(settled), 1);
    repeat (10) @(negedge clk);
    check("estop_cmd_dropped_left", int'(left_duty), 0);
    check("estop_cmd_dropped_dir", int'(dir), 0);

    // Stop from spin-left keeps direction
    send("spinl", 3'd4);
    wait_settled("spinl");
    check("spinl_dir", int'(dir), 2);
    check("spinl_left", int'(left_duty), 300);
    send("halt", 3'd0);
    wait_settled("halt");
    check("halt_left", int'(left_duty), 0);
    check("halt_right", int'(right_duty), 0);
    check("halt_dir", int'(dir), 2);
    check("halt_settled", int'(settled), 1);

    // Asynchronous reset in the middle of DEAD
    send("spinl2", 3'd4);
    wait_settled("spinl2");
    send("spinr", 3'd5);
    wait_left("spinr_brake", 0);
    repeat (4) @(negedge clk);
    check("dead_pre_settled", int'(settled), 0);
    check("dead_pre_dir", int'(dir), 2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_settled", int'(settled), 1);
    check("async_rst_ready", int'(mode_ready), 0);
    check("async_rst_dir", int'(dir), 0);
    check("async_rst_left", int'(left_duty), 0);
    check("async_rst_right", int'(right_duty), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_idle_left", int'(left_duty), 0);
    check("post_rst_idle_dir", int'(dir), 0);
    send("fwd4", 3'd1);
    ramp_watch("post_rst_ramp", 1'b1, 300, 38, 1, -1);
    wait_settled("fwd4");
    check("post_rst_dir", int'(dir), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
